// File: rtl/formula_isqrt_sum_n_fsm.sv
`default_nettype none
// ============================================================================
// Module : formula_isqrt_sum_n_fsm
// Sums isqrt(x[i]) over N_ARGS operands, dispatched in rounds to N_ISQRT units.
// Rev    : 1.0  initial release
// ============================================================================
module formula_isqrt_sum_n_fsm #(
  parameter int N_ARGS  = 3,
  parameter int N_ISQRT = 2,
  parameter int W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arg_vld,
  input  logic [N_ARGS*W-1:0]    args,
  output logic                   busy,
  output logic                   res_vld,
  output logic [W-1:0]           res,
  output logic [N_ISQRT-1:0]     isqrt_x_vld,
  output logic [N_ISQRT*W-1:0]   isqrt_x,
  input  logic [N_ISQRT-1:0]     isqrt_y_vld,
  input  logic [N_ISQRT*W/2-1:0] isqrt_y
);

  localparam int c_H      = W / 2;
  localparam int c_ROUNDS = (N_ARGS + N_ISQRT - 1) / N_ISQRT;
  localparam int c_RND_W  = (c_ROUNDS > 1) ? $clog2(c_ROUNDS) : 1;
  localparam logic [c_RND_W-1:0] c_LAST_RND = c_RND_W'(c_ROUNDS - 1);
  localparam logic [c_RND_W-1:0] c_RND_ONE  = c_RND_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [N_ARGS*W-1:0]  r_args;
  logic [W-1:0]         r_acc;
  logic [c_RND_W-1:0]   r_round;
  logic [N_ISQRT-1:0]   r_mask;
  logic [N_ISQRT-1:0]   r_done;

  logic [N_ISQRT-1:0]   w_lane_act;
  logic [N_ISQRT*W-1:0] w_lane_x;
  logic [N_ISQRT-1:0]   w_hit;
  logic [W-1:0]         w_add;
  logic                 w_all_done;
  logic                 w_last;

  // Each lane picks its operand for the current round; index range is resolved
  // at elaboration so the final partial round simply has no candidate.
  for (genvar j = 0; j < N_ISQRT; j++) begin : g_lane
    logic [c_ROUNDS-1:0] w_avail;
    logic [W-1:0]        w_cand [c_ROUNDS];

    for (genvar r = 0; r < c_ROUNDS; r++) begin : g_rnd
      if (r * N_ISQRT + j < N_ARGS) begin : g_used
        assign w_avail[r] = 1'b1;
        assign w_cand[r]  = r_args[(r*N_ISQRT+j)*W +: W];
      end else begin : g_unused
        assign w_avail[r] = 1'b0;
        assign w_cand[r]  = '0;
      end
    end

    assign w_lane_act[j]       = w_avail[r_round];
    assign w_lane_x[j*W +: W]  = w_cand[r_round];
    assign w_hit[j]            = isqrt_y_vld[j] & r_mask[j] & ~r_done[j];
  end

  always_comb begin
    w_add = '0;
    for (int j = 0; j < N_ISQRT; j++) begin
      if (w_hit[j]) begin
        w_add = w_add + {{(W-c_H){1'b0}}, isqrt_y[j*c_H +: c_H]};
      end
    end
  end

  assign w_all_done = (((r_done | w_hit) & r_mask) == r_mask);
  assign w_last     = (r_round == c_LAST_RND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    res_vld     = 1'b0;
    res         = '0;
    isqrt_x_vld = '0;
    isqrt_x     = '0;
    case (r_state)
      S_IDLE: begin
        if (arg_vld) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        isqrt_x_vld = w_lane_act;
        isqrt_x     = w_lane_x;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_all_done) w_state_nxt = w_last ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        res_vld     = 1'b1;
        res         = r_acc;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_args  <= '0;
      r_acc   <= '0;
      r_round <= '0;
      r_mask  <= '0;
      r_done  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (arg_vld) begin
            r_args  <= args;
            r_acc   <= '0;
            r_round <= '0;
          end
        end
        S_ISSUE: begin
          r_mask <= w_lane_act;
          r_done <= '0;
        end
        S_WAIT: begin
          r_acc  <= r_acc + w_add;
          r_done <= r_done | w_hit;
          if (w_all_done && !w_last) r_round <= r_round + c_RND_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_formula_isqrt_sum_n_fsm.sv
`default_nettype none
// ============================================================================
// Module : tb_formula_isqrt_sum_n_fsm
// Bench for formula_isqrt_sum_n_fsm with a delayed-isqrt responder model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_formula_isqrt_sum_n_fsm;

  localparam int N_ARGS  = 3;
  localparam int N_ISQRT = 2;
  localparam int W       = 32;
  localparam int H       = W / 2;
  localparam int ROUNDS  = (N_ARGS + N_ISQRT - 1) / N_ISQRT;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 arg_vld = 1'b0;
  logic [N_ARGS*W-1:0]  args = '0;
  logic                 busy;
  logic                 res_vld;
  logic [W-1:0]         res;
  logic [N_ISQRT-1:0]   isqrt_x_vld;
  logic [N_ISQRT*W-1:0] isqrt_x;
  logic [N_ISQRT-1:0]   isqrt_y_vld;
  logic [N_ISQRT*H-1:0] isqrt_y;

  int n_cmp = 0;
  int n_bad = 0;
  int n_strobes = 0;
  int exp_strobes = 0;

  logic [W-1:0] cur_args [N_ARGS];
  int           issue_idx = 0;
  int           fix_delay = 1;
  int           lane_extra [N_ISQRT];
  bit           noise_en = 1'b0;
  int           cnt [N_ISQRT];
  logic [H-1:0] pend_y [N_ISQRT];

  formula_isqrt_sum_n_fsm #(.N_ARGS(N_ARGS), .N_ISQRT(N_ISQRT), .W(W)) dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .args(args),
    .busy(busy), .res_vld(res_vld), .res(res),
    .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
    .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Largest r with r*r <= x, found by plain integer arithmetic.
  function automatic logic [H-1:0] ref_isqrt(input logic [W-1:0] x);
    longint r;
    r = 0;
    while ((r + 1) * (r + 1) <= longint'(x)) begin
      if ((r + 256) * (r + 256) <= longint'(x)) r = r + 256;
      else r = r + 1;
    end
    return H'(r);
  endfunction

  // Each round lasts (slowest active lane + 1) cycles, plus one cycle to ISSUE up front.
  function automatic int exp_latency();
    int lat;
    int mx;
    lat = 1;
    for (int r = 0; r < ROUNDS; r++) begin
      mx = 0;
      for (int j = 0; j < N_ISQRT; j++)
        if (r * N_ISQRT + j < N_ARGS && fix_delay + lane_extra[j] > mx) mx = fix_delay + lane_extra[j];
      lat = lat + mx + 1;
    end
    return lat;
  endfunction

  // Responder: models the isqrt bank and checks each request against the argument vector.
  initial begin
    logic [N_ISQRT-1:0]   ev;
    logic [N_ISQRT*W-1:0] ex;
    int idx;
    isqrt_y_vld = '0;
    isqrt_y     = '0;
    for (int j = 0; j < N_ISQRT; j++) begin
      cnt[j] = 0;
      pend_y[j] = '0;
      lane_extra[j] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int j = 0; j < N_ISQRT; j++) begin
        isqrt_y_vld[j] = 1'b0;
        if (cnt[j] > 0) begin
          cnt[j] = cnt[j] - 1;
          if (cnt[j] == 0) begin
            isqrt_y_vld[j] = 1'b1;
            isqrt_y[j*H +: H] = pend_y[j];
          end
        end else if (noise_en && $urandom_range(3) == 0) begin
          isqrt_y_vld[j] = 1'b1;
          isqrt_y[j*H +: H] = H'($urandom);
        end
      end
      if (isqrt_x_vld != '0) begin
        ev = '0;
        ex = '0;
        for (int j = 0; j < N_ISQRT; j++) begin
          idx = issue_idx * N_ISQRT + j;
          if (idx < N_ARGS) begin
            ev[j] = 1'b1;
            ex[j*W +: W] = cur_args[idx];
          end
        end
        check_eq("issue_vld", 64'(isqrt_x_vld), 64'(ev));
        check_eq("issue_x", 64'(isqrt_x), 64'(ex));
        issue_idx++;
        for (int j = 0; j < N_ISQRT; j++) begin
          if (isqrt_x_vld[j]) begin
            check_eq("lane_overlap", 64'(cnt[j]), 64'd0);
            pend_y[j] = ref_isqrt(isqrt_x[j*W +: W]);
            cnt[j] = (fix_delay > 0) ? fix_delay + lane_extra[j] : int'($urandom_range(5, 1));
          end
        end
      end
    end
  end

  // Output-shape monitor.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (!res_vld) check_eq("res_zero", 64'(res), 64'd0);
      if (isqrt_x_vld == '0) check_eq("x_zero", 64'(isqrt_x), 64'd0);
      check_eq("vld_excl", 64'(res_vld & (|isqrt_x_vld)), 64'd0);
      if (res_vld) n_strobes++;
    end
  end

  task automatic rand_args();
    for (int i = 0; i < N_ARGS; i++) args[i*W +: W] = W'($urandom);
  endtask

  task automatic run_txn(input logic [N_ARGS*W-1:0] pv, input bit noisy, input int exp_lat);
    logic [W-1:0] exp_res;
    int cyc;
    cyc = 0;
    while (busy && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("idle_before", 64'(busy), 64'd0);
    exp_res = '0;
    for (int i = 0; i < N_ARGS; i++) begin
      cur_args[i] = pv[i*W +: W];
      exp_res = exp_res + W'(ref_isqrt(cur_args[i]));
    end
    issue_idx = 0;
    noise_en = noisy;
    exp_strobes++;
    args = pv;
    arg_vld = 1'b1;
    @(posedge clk);
    #1;
    arg_vld = 1'b0;
    cyc = 1;
    while (!res_vld && cyc < 400) begin
      if (noisy) begin
        arg_vld = 1'($urandom_range(1));
        rand_args();
      end else begin
        arg_vld = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("res_seen", 64'(res_vld), 64'd1);
    check_eq("res", 64'(res), 64'(exp_res));
    if (exp_lat > 0) check_eq("latency", 64'(cyc), 64'(exp_lat));
    if (noisy) begin
      arg_vld = 1'b1;
      rand_args();
    end
    @(posedge clk);
    #1;
    arg_vld = 1'b0;
    check_eq("done_1cyc", 64'(res_vld), 64'd0);
    check_eq("idle_after", 64'(busy), 64'd0);
    noise_en = 1'b0;
  endtask

  initial begin
    logic [N_ARGS*W-1:0] pv;
    logic [W-1:0] v;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_res_vld", 64'(res_vld), 64'd0);
    check_eq("rst_res", 64'(res), 64'd0);
    check_eq("rst_x_vld", 64'(isqrt_x_vld), 64'd0);
    check_eq("rst_x", 64'(isqrt_x), 64'd0);
    rst = 1'b0;

    fix_delay = 1;
    run_txn({32'd36, 32'd25, 32'd16}, 1'b0, exp_latency());
    lane_extra[1] = 3;
    run_txn({32'd36, 32'd25, 32'd16}, 1'b0, exp_latency());
    lane_extra[1] = 0;
    run_txn({32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 1'b0, exp_latency());
    run_txn({32'd100, 32'd49, 32'd9}, 1'b1, exp_latency());

    // Abort a transaction mid-WAIT; its responses arrive after reset release.
    fix_delay = 6;
    pv = {32'd81, 32'd64, 32'd49};
    for (int i = 0; i < N_ARGS; i++) cur_args[i] = pv[i*W +: W];
    issue_idx = 0;
    args = pv;
    arg_vld = 1'b1;
    @(posedge clk);
    #1;
    arg_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_res_vld", 64'(res_vld), 64'd0);
    check_eq("arst_res", 64'(res), 64'd0);
    check_eq("arst_x_vld", 64'(isqrt_x_vld), 64'd0);
    check_eq("arst_x", 64'(isqrt_x), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      check_eq("late_y_ignored", 64'(busy), 64'd0);
    end
    fix_delay = 1;
    run_txn({32'd4, 32'd1, 32'd0}, 1'b0, exp_latency());

    fix_delay = 0;
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < N_ARGS; i++) begin
        case ($urandom_range(2))
          0: v = W'($urandom);
          1: begin
            v = W'($urandom_range(65535));
            v = v * v;
          end
          default: v = W'($urandom_range(20));
        endcase
        pv[i*W +: W] = v;
      end
      run_txn(pv, 1'(k % 2), 0);
    end

    repeat (2) @(posedge clk);
    #1;
    check_eq("strobes", 64'(n_strobes), 64'(exp_strobes));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
